// File: rtl/mult_iter_if.sv
// rtl/mult_iter_if.sv - start/operand/result bundle for the iterative multiplier
interface mult_iter_if #(
  parameter int WIDTH = 32
);
  logic             _go;
  logic [WIDTH-1:0] left;
  logic [WIDTH-1:0] right;
  logic [WIDTH-1:0] out;
  logic             done;
  logic             busy;

  modport master (output _go, left, right, input out, done, busy);
  modport slave  (input _go, left, right, output out, done, busy);
endinterface

// File: rtl/mult_iter.sv
// rtl/mult_iter.sv - iterative shift-add multiplier, WIDTH-bit product held between operations
// Optional macro MULT_ITER_EARLY_EXIT_EN: leave BUSY as soon as the remaining multiplier bits are zero.
module mult_iter #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  mult_iter_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e           state_q,  state_d;
  logic [WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q,    acc_d;
  logic [WIDTH-1:0] out_q,    out_d;
  logic [CW-1:0]    cnt_q,    cnt_d;

  logic [WIDTH-1:0] acc_sum;
  logic [WIDTH-1:0] mplier_shift;
  logic             last_iter;

  always_comb begin
    acc_sum      = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    mplier_shift = mplier_q >> 1;
`ifdef MULT_ITER_EARLY_EXIT_EN
    last_iter    = (cnt_q == CW'(WIDTH - 1)) || (mplier_shift == '0);
`else
    last_iter    = (cnt_q == CW'(WIDTH - 1));
`endif
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    out_d    = out_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus._go) begin
          state_d  = BUSY;
          mcand_d  = bus.left;
          mplier_d = bus.right;
          acc_d    = '0;
          cnt_d    = '0;
        end else begin
          state_d  = IDLE;
        end
      end
      BUSY: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_shift;
        cnt_d    = cnt_q + 1'b1;
        // out is only written here, so it holds across later starts until the next result
        if (last_iter) begin
          state_d = DONE;
          out_d   = acc_sum;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      out_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      out_q    <= out_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.out  = out_q;
  assign bus.done = (state_q == DONE);
  assign bus.busy = (state_q == BUSY);

endmodule
